// File: rtl/div_pkg.sv
// Shared types, widths and helpers for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Finished result as presented to the consumer
    typedef struct packed {
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] r;
    } div_rsp_t;

    // Two's-complement negate when neg is set, pass through otherwise
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
        cond_neg = neg ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// Operand/result handshake bundle between the execute stage and the divider.
interface div_if;
    import div_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              div_signed;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              cancel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;

    modport master (
        output in_valid, div_signed, x, y, cancel, out_ready,
        input  in_ready, out_valid, s, r
    );

    modport slave (
        input  in_valid, div_signed, x, y, cancel, out_ready,
        output in_ready, out_valid, s, r
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned W = div_pkg::DATA_W
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_dvs,
    output logic [W-1:0] o_rem_c,
    output logic         o_q_c
);

    logic [W:0] w_shift;
    logic [W:0] w_diff;

    // Partial remainder is W+1 bits wide so the trial difference sign is exact
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_dvs};
        o_q_c   = ~w_diff[W];
        o_rem_c = o_q_c ? w_diff[W-1:0] : w_shift[W-1:0];
    end

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with sign correction and cancel.
module div
    import div_pkg::*;
(
    input  logic div_clk,
    input  logic reset,
    div_if.slave bus
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;

    logic               w_accept;
    logic               w_step_en;
    logic               w_finish;

    logic [DATA_W-1:0]  r_dvd;
    logic [DATA_W-1:0]  r_dvs;
    logic [DATA_W-1:0]  r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_qsign;
    logic               r_rsign;
    div_rsp_t           r_rsp;

    logic [DATA_W-1:0]  w_rem_nxt;
    logic               w_qbit;
    logic               w_x_neg;
    logic               w_y_neg;
    logic               w_iter_done;

    assign w_x_neg     = bus.div_signed & bus.x[DATA_W-1];
    assign w_y_neg     = bus.div_signed & bus.y[DATA_W-1];
    assign w_iter_done = (r_cnt == CNT_W'(DATA_W));

    div_step #(.W(DATA_W)) u_step (
        .i_rem   (r_rem),
        .i_bit   (r_dvd[DATA_W-1]),
        .i_dvs   (r_dvs),
        .o_rem_c (w_rem_nxt),
        .o_q_c   (w_qbit)
    );

    // State register
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; cancel overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        if (bus.cancel) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.in_valid)  w_state_nxt = BUSY;
                BUSY:    if (w_iter_done)   w_state_nxt = DONE;
                DONE:    if (bus.out_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output/control decode; handshake flags track the state being entered
    always_comb begin
        w_accept        = 1'b0;
        w_step_en       = 1'b0;
        w_finish        = 1'b0;
        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == DONE);
        if (!bus.cancel) begin
            case (r_state)
                IDLE: w_accept = bus.in_valid;
                BUSY: begin
                    w_step_en = ~w_iter_done;
                    w_finish  = w_iter_done;
                end
                default: ;
            endcase
        end
    end

    // Registered handshake outputs
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Operand magnitudes, partial remainder and iteration count
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
        end else if (w_accept) begin
            r_dvd   <= cond_neg(bus.x, w_x_neg);
            r_dvs   <= cond_neg(bus.y, w_y_neg);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_qsign <= w_x_neg ^ w_y_neg;
            r_rsign <= w_x_neg;
        end else if (w_step_en) begin
            r_dvd   <= {r_dvd[DATA_W-2:0], w_qbit};
            r_rem   <= w_rem_nxt;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Sign-corrected result, loaded only on entry to DONE
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            r_rsp <= '0;
        end else if (w_finish) begin
            r_rsp.s <= cond_neg(r_dvd, r_qsign);
            r_rsp.r <= cond_neg(r_rem, r_rsign);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_rsp.s;
    assign bus.r         = r_rsp.r;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: arithmetic reference model plus directed corner cases.
module tb_div;
    import div_pkg::*;

    localparam int LAT = DATA_W + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_if bus ();

    div u_dut (
        .div_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: plain integer division (truncating), divide-by-zero per magnitude rule
    function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] rm);
        longint sa, sb;
        if (!sg) begin
            if (b == 32'd0) begin q = 32'hFFFFFFFF; rm = a; end
            else begin q = a / b; rm = a % b; end
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (sb == 0) begin
                q  = (sa < 0) ? 32'd1 : 32'hFFFFFFFF;
                rm = a;
            end else begin
                q  = 32'(sa / sb);
                rm = 32'(sa % sb);
            end
        end
    endfunction

    // Cycle-level expectation: one outstanding op, result visible LAT edges after acceptance
    bit          m_busy = 1'b0;
    int          m_edges = 0;
    logic [31:0] m_s, m_r;
    bit          m_was_busy;
    bit          m_exp_ov;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
            if (m_busy) m_edges++;
            m_exp_ov = m_busy && (m_edges >= LAT);
            chk("in_ready", 32'(bus.in_ready), 32'(!m_busy));
            chk("out_valid", 32'(bus.out_valid), 32'(m_exp_ov));
            if (m_exp_ov) begin
                chk("s", bus.s, m_s);
                chk("r", bus.r, m_r);
            end
            m_was_busy = m_busy;
            if (m_busy && (bus.cancel || (m_exp_ov && bus.out_ready))) m_busy = 1'b0;
            if (!m_was_busy && bus.in_valid && !bus.cancel) begin
                m_busy  = 1'b1;
                m_edges = -1;
                model(bus.div_signed, bus.x, bus.y, m_s, m_r);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] es, input logic [31:0] er, input int hold);
        logic [31:0] ms, mr;
        int n;
        model(sg, a, b, ms, mr);
        chk("model_s", ms, es);
        chk("model_r", mr, er);
        bus.div_signed = sg;
        bus.x          = a;
        bus.y          = b;
        bus.in_valid   = 1'b1;
        wait_clk();
        bus.in_valid   = 1'b0;
        bus.div_signed = 1'($urandom);
        bus.x          = $urandom;
        bus.y          = $urandom;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            wait_clk();
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        chk("lit_s", bus.s, es);
        chk("lit_r", bus.r, er);
        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.x        = $urandom;
            bus.y        = $urandom;
            wait_clk();
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_s", bus.s, es);
            chk("hold_r", bus.r, er);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_clk();
        bus.out_ready = 1'b0;
        chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    logic        rs;
    logic [31:0] ra, rb;
    int          rsel, rn;

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.div_signed = 1'b0;
        bus.x          = '0;
        bus.y          = '0;
        bus.cancel     = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_s", bus.s, 32'd0);
        chk("reset_r", bus.r, 32'd0);
        rst = 1'b0;
        wait_clk();

        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0);
        run_op(1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 10);

        // in_valid together with cancel in IDLE must not be accepted
        bus.div_signed = 1'b0;
        bus.x          = 32'd50;
        bus.y          = 32'd5;
        bus.in_valid   = 1'b1;
        bus.cancel     = 1'b1;
        wait_clk();
        bus.in_valid   = 1'b0;
        bus.cancel     = 1'b0;
        chk("cancel_idle_in_ready", 32'(bus.in_ready), 32'd1);

        // cancel at iteration 15
        bus.x        = 32'd1000;
        bus.y        = 32'd3;
        bus.in_valid = 1'b1;
        wait_clk();
        bus.in_valid = 1'b0;
        repeat (15) wait_clk();
        bus.cancel = 1'b1;
        wait_clk();
        bus.cancel = 1'b0;
        chk("cancel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("cancel_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (40) wait_clk();

        // reset at iteration 20
        bus.x        = 32'd77777;
        bus.y        = 32'd13;
        bus.in_valid = 1'b1;
        wait_clk();
        bus.in_valid = 1'b0;
        repeat (20) wait_clk();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_s", bus.s, 32'd0);
        chk("midrst_r", bus.r, 32'd0);
        wait_clk();
        rst = 1'b0;
        wait_clk();
        run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

        // randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 60; i++) begin
            rs   = 1'($urandom);
            ra   = $urandom;
            rsel = int'($urandom_range(5, 0));
            case (rsel)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(15, 1));
                2:       rb = -32'($urandom_range(15, 1));
                3:       begin ra = 32'h80000000; rb = $urandom; end
                default: rb = $urandom;
            endcase
            bus.div_signed = rs;
            bus.x          = ra;
            bus.y          = rb;
            bus.in_valid   = 1'b1;
            wait_clk();
            bus.in_valid   = 1'b0;
            if ($urandom_range(7, 0) == 0) begin
                repeat ($urandom_range(40, 1)) wait_clk();
                bus.cancel    = 1'b1;
                bus.out_ready = 1'($urandom);
                wait_clk();
                bus.cancel    = 1'b0;
                bus.out_ready = 1'b0;
            end else begin
                rn = 0;
                while (!bus.out_valid && rn < 100) begin
                    wait_clk();
                    rn++;
                end
                chk("rand_latency", 32'(rn), 32'(LAT));
                repeat ($urandom_range(3, 0)) wait_clk();
                bus.out_ready = 1'b1;
                wait_clk();
                bus.out_ready = 1'b0;
            end
        end

        repeat (2) wait_clk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
